mgmt_data_channel_controller: RTL and testbench

Controller-side (initiator) data channel management for LTPI, the counterpart of the target-side responder. Takes one request payload from the local request queue and places it on the TX data channel at a frame boundary. Stamps each request with a rolling tag, then waits for the target's matching response in received data-channel frames. Returns the response, or a timeout status, to the requester through a valid/ack handshake.

---
 rtl/mgmt_data_channel_controller_if.sv | 39 +++
 rtl/mgmt_data_channel_controller.sv | 156 +++++++++++++++
 tb/tb_mgmt_data_channel_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_data_channel_controller_if.sv
// Shared payload type and the request/response/data-channel bundle between
// the LTPI controller-side data channel manager and its environment.
package mgmt_dc_pkg;
   typedef struct packed {
      logic [7:0]  tag;
      logic [7:0]  command;
      logic [15:0] address;
      logic [31:0] data;
   } Data_channel_payload_t;

   // Last byte offset of a TX frame: payloads are swapped only here.
   localparam logic [3:0] frame_length = 4'd15;
endpackage

interface mgmt_data_channel_controller_if;
   import mgmt_dc_pkg::*;

   logic                  req_valid;
   logic                  req_ack;
   Data_channel_payload_t req;
   Data_channel_payload_t payload_o;
   logic                  payload_o_valid;
   Data_channel_payload_t payload_i;
   logic                  payload_i_valid;
   logic                  resp_valid;
   logic                  resp_ack;
   Data_channel_payload_t resp;
   logic                  resp_timeout;

   modport master (
      input  req_valid, req, payload_i, payload_i_valid, resp_ack,
      output req_ack, payload_o, payload_o_valid, resp_valid, resp, resp_timeout
   );

   modport slave (
      output req_valid, req, payload_i, payload_i_valid, resp_ack,
      input  req_ack, payload_o, payload_o_valid, resp_valid, resp, resp_timeout
   );
endinterface

// File: rtl/mgmt_data_channel_controller.sv
// Controller-side LTPI data channel: sends one tagged request per TX frame,
// then waits for the tag-matched response or a frame-count timeout.
module mgmt_data_channel_controller
   import mgmt_dc_pkg::*;
#(
   parameter int unsigned TIMEOUT_FRAMES = 32,
   parameter int unsigned TAG_W          = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   mgmt_data_channel_controller_if.master      bus,
   input  logic [3:0]                          tx_frm_offset,
   input  logic [31:0]                         operational_frm_sent,
   input  logic [31:0]                         operational_frm_rcv,
   input  logic                                data_channel_rst
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SEND      = 3'd1;
   localparam logic [2:0] SEND_DLY  = 3'd2;
   localparam logic [2:0] WAIT_RESP = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

   logic [2:0]            state_q, state_d;
   Data_channel_payload_t payload_q, payload_d;
   Data_channel_payload_t resp_q, resp_d;
   logic                  payload_valid_q, payload_valid_d;
   logic                  req_ack_q, req_ack_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_timeout_q, resp_timeout_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [31:0]           sent_latch_q, sent_latch_d;
   logic [31:0]           rcv_latch_q, rcv_latch_d;

   logic                  frame_edge;
   logic                  tag_match;
   logic                  timeout_hit;
   logic [31:0]           frames_waited;

   assign frame_edge    = (tx_frm_offset == frame_length);
   assign tag_match     = bus.payload_i_valid && (bus.payload_i.tag == tag_q);
   // Modulo difference keeps the timeout correct across counter wrap.
   assign frames_waited = operational_frm_rcv - rcv_latch_q;
   assign timeout_hit   = (frames_waited >= TIMEOUT_FRAMES);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d         = state_q;
      payload_d       = payload_q;
      payload_valid_d = payload_valid_q;
      req_ack_d       = 1'b0;
      resp_d          = resp_q;
      resp_valid_d    = resp_valid_q;
      resp_timeout_d  = resp_timeout_q;
      tag_d           = tag_q;
      sent_latch_d    = sent_latch_q;
      rcv_latch_d     = rcv_latch_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && frame_edge) begin
               payload_d       = bus.req;
               payload_d.tag   = tag_q;
               payload_valid_d = 1'b1;
               req_ack_d       = 1'b1;
               state_d         = SEND;
            end
         end
         SEND: begin
            if (!frame_edge) begin
               sent_latch_d = operational_frm_sent;
               state_d      = SEND_DLY;
            end
         end
         SEND_DLY: begin
            if (frame_edge) begin
               payload_valid_d = 1'b0;
               rcv_latch_d     = operational_frm_rcv;
               state_d         = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // A matching frame outranks a timeout landing in the same cycle.
            if (tag_match) begin
               resp_d         = bus.payload_i;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b0;
               state_d        = DONE;
            end else if (timeout_hit) begin
               resp_d         = '0;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b1;
               state_d        = DONE;
            end
         end
         DONE: begin
            if (bus.resp_ack) begin
               resp_valid_d   = 1'b0;
               resp_timeout_d = 1'b0;
               tag_d          = tag_q + 1'b1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Data channel reset aborts any transaction; a popped request is lost.
      if (data_channel_rst) begin
         state_d         = IDLE;
         payload_d       = '0;
         payload_valid_d = 1'b0;
         req_ack_d       = 1'b0;
         resp_d          = '0;
         resp_valid_d    = 1'b0;
         resp_timeout_d  = 1'b0;
         tag_d           = '0;
         sent_latch_d    = '0;
         rcv_latch_d     = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         payload_q       <= '0;
         payload_valid_q <= 1'b0;
         req_ack_q       <= 1'b0;
         resp_q          <= '0;
         resp_valid_q    <= 1'b0;
         resp_timeout_q  <= 1'b0;
         tag_q           <= '0;
         sent_latch_q    <= '0;
         rcv_latch_q     <= '0;
      end else begin
         state_q         <= state_d;
         payload_q       <= payload_d;
         payload_valid_q <= payload_valid_d;
         req_ack_q       <= req_ack_d;
         resp_q          <= resp_d;
         resp_valid_q    <= resp_valid_d;
         resp_timeout_q  <= resp_timeout_d;
         tag_q           <= tag_d;
         sent_latch_q    <= sent_latch_d;
         rcv_latch_q     <= rcv_latch_d;
      end
   end

   assign bus.req_ack         = req_ack_q;
   assign bus.payload_o       = payload_q;
   assign bus.payload_o_valid = payload_valid_q;
   assign bus.resp            = resp_q;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_timeout    = resp_timeout_q;

endmodule

// File: tb/tb_mgmt_data_channel_controller.sv
// Directed bench for mgmt_data_channel_controller: a cycle table for the basic
// transaction plus hand sequences for tags, timeouts, wrap and resets.
module tb_mgmt_data_channel_controller;
   import mgmt_dc_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  tx_frm_offset;
   logic [31:0] frm_sent;
   logic [31:0] frm_rcv;
   logic        dc_rst;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_tag;

   Data_channel_payload_t req_base;
   Data_channel_payload_t rsp_base;

   mgmt_data_channel_controller_if bus();

   mgmt_data_channel_controller #(
      .TIMEOUT_FRAMES(TO),
      .TAG_W         (8)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .bus                 (bus),
      .tx_frm_offset       (tx_frm_offset),
      .operational_frm_sent(frm_sent),
      .operational_frm_rcv (frm_rcv),
      .data_channel_rst    (dc_rst)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req_valid;
      logic [3:0]  off;
      logic        pi_valid;
      logic [7:0]  pi_tag;
      logic [31:0] rcv;
      logic        resp_ack;
      logic        e_req_ack;
      logic        e_po_valid;
      logic        e_resp_valid;
      logic        e_resp_to;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic Data_channel_payload_t with_tag(input Data_channel_payload_t p,
                                                      input logic [7:0] t);
      Data_channel_payload_t r;
      r     = p;
      r.tag = t;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      frm_sent = frm_sent + 32'd1;
   endtask

   // Pops one request and drives it through SEND/SEND_DLY into WAIT_RESP.
   task automatic start_txn(input logic [31:0] rcv0);
      bus.req_valid = 1'b1;
      tx_frm_offset = frame_length;
      step();
      check("txn_req_ack", bus.req_ack, 1'b1);
      check("txn_payload_o", bus.payload_o, with_tag(req_base, exp_tag));
      bus.req_valid = 1'b0;
      tx_frm_offset = 4'd0;
      step();
      check("txn_req_ack_pulse", bus.req_ack, 1'b0);
      tx_frm_offset = frame_length;
      frm_rcv       = rcv0;
      step();
      check("txn_po_valid_drop", bus.payload_o_valid, 1'b0);
      tx_frm_offset = 4'd0;
   endtask

   task automatic send_rsp(input logic [7:0] t);
      bus.payload_i_valid = 1'b1;
      bus.payload_i       = with_tag(rsp_base, t);
      step();
      bus.payload_i_valid = 1'b0;
   endtask

   task automatic finish_txn();
      bus.resp_ack = 1'b1;
      step();
      check("ack_clears_valid", bus.resp_valid, 1'b0);
      bus.resp_ack = 1'b0;
      exp_tag      = exp_tag + 8'd1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_req_ack"},  bus.req_ack, 1'b0);
      check({name, "_po_valid"}, bus.payload_o_valid, 1'b0);
      check({name, "_payload"},  bus.payload_o, 64'h0);
      check({name, "_rvalid"},   bus.resp_valid, 1'b0);
      check({name, "_rto"},      bus.resp_timeout, 1'b0);
      check({name, "_resp"},     bus.resp, 64'h0);
   endtask

   initial begin
      req_base = '{tag: 8'hEE, command: 8'h01, address: 16'hA5C3, data: 32'h1122_3344};
      rsp_base = '{tag: 8'h00, command: 8'h81, address: 16'h1234, data: 32'hCAFE_F00D};

      //            rv    off    piv   tag    rcv     ack   rack  pov   rv    rto
      vecs[0]  = '{1'b1, 4'd3,  1'b0, 8'h00, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd15, 1'b0, 8'h00, 32'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'd15, 1'b0, 8'h00, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'd0,  1'b0, 8'h00, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'd7,  1'b0, 8'h00, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd15, 1'b0, 8'h00, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd0,  1'b0, 8'h00, 32'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 4'd0,  1'b1, 8'h00, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 4'd15, 1'b0, 8'h00, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'd0,  1'b0, 8'h00, 32'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'd0,  1'b0, 8'h00, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset_n             = 1'b0;
      dc_rst              = 1'b0;
      tx_frm_offset       = 4'd0;
      frm_sent            = 32'd0;
      frm_rcv             = 32'd0;
      bus.req_valid       = 1'b0;
      bus.req             = req_base;
      bus.payload_i       = '0;
      bus.payload_i_valid = 1'b0;
      bus.resp_ack        = 1'b0;
      exp_tag             = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      step();

      // Basic transaction, cycle by cycle.
      for (int i = 0; i < 11; i++) begin
         bus.req_valid       = vecs[i].req_valid;
         tx_frm_offset       = vecs[i].off;
         bus.payload_i_valid = vecs[i].pi_valid;
         bus.payload_i       = with_tag(rsp_base, vecs[i].pi_tag);
         frm_rcv             = vecs[i].rcv;
         bus.resp_ack        = vecs[i].resp_ack;
         step();
         check($sformatf("vec%0d_req_ack", i),  bus.req_ack, vecs[i].e_req_ack);
         check($sformatf("vec%0d_po_valid", i), bus.payload_o_valid, vecs[i].e_po_valid);
         check($sformatf("vec%0d_rvalid", i),   bus.resp_valid, vecs[i].e_resp_valid);
         check($sformatf("vec%0d_rto", i),      bus.resp_timeout, vecs[i].e_resp_to);
         if (vecs[i].e_po_valid)
            check($sformatf("vec%0d_payload_o", i), bus.payload_o, with_tag(req_base, 8'h00));
         if (vecs[i].e_resp_valid)
            check($sformatf("vec%0d_resp", i), bus.resp, with_tag(rsp_base, 8'h00));
      end
      bus.payload_i_valid = 1'b0;
      bus.resp_ack        = 1'b0;
      exp_tag             = 8'h01;

      // Wrong tag is dropped, matching tag is returned.
      start_txn(32'd20);
      send_rsp(8'h05);
      check("mismatch_dropped", bus.resp_valid, 1'b0);
      send_rsp(exp_tag);
      check("match_valid", bus.resp_valid, 1'b1);
      check("match_rto", bus.resp_timeout, 1'b0);
      check("match_resp", bus.resp, with_tag(rsp_base, exp_tag));
      finish_txn();

      // Timeout after exactly TO frames, then a stale late frame is ignored.
      start_txn(32'd100);
      frm_rcv = 32'd103;
      step();
      check("to_not_early", bus.resp_valid, 1'b0);
      frm_rcv = 32'd104;
      step();
      check("to_valid", bus.resp_valid, 1'b1);
      check("to_flag", bus.resp_timeout, 1'b1);
      check("to_resp_zero", bus.resp, 64'h0);
      step();
      check("to_held", bus.resp_valid, 1'b1);
      finish_txn();
      start_txn(32'd200);
      send_rsp(exp_tag - 8'd1);
      check("late_dropped", bus.resp_valid, 1'b0);
      send_rsp(exp_tag);
      check("after_late_valid", bus.resp_valid, 1'b1);
      check("after_late_rto", bus.resp_timeout, 1'b0);
      finish_txn();

      // Timeout across the 32-bit counter wrap.
      start_txn(32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         frm_rcv = frm_rcv + 32'd1;
         step();
         check($sformatf("wrap_not_early_%0d", k), bus.resp_valid, 1'b0);
      end
      frm_rcv = 32'h0000_0002;
      step();
      check("wrap_valid", bus.resp_valid, 1'b1);
      check("wrap_rto", bus.resp_timeout, 1'b1);
      finish_txn();

      // Matching frame in the same cycle as the timeout wins.
      start_txn(32'd50);
      frm_rcv = 32'd54;
      send_rsp(exp_tag);
      check("tie_valid", bus.resp_valid, 1'b1);
      check("tie_rto", bus.resp_timeout, 1'b0);
      check("tie_resp", bus.resp, with_tag(rsp_base, exp_tag));
      finish_txn();

      // data_channel_rst in WAIT_RESP beats a matching frame and a timeout.
      start_txn(32'd300);
      dc_rst              = 1'b1;
      frm_rcv             = 32'd400;
      bus.payload_i_valid = 1'b1;
      bus.payload_i       = with_tag(rsp_base, exp_tag);
      step();
      check_all_zero("dcrst");
      dc_rst              = 1'b0;
      bus.payload_i_valid = 1'b0;
      repeat (3) step();
      check("dcrst_no_resp", bus.resp_valid, 1'b0);
      exp_tag = 8'h00;

      // Tag sequence 0x00..0xFF then back to 0x00.
      for (int n = 0; n < 257; n++) begin
         start_txn(32'd1000);
         send_rsp(exp_tag);
         check($sformatf("tagwrap_%0d_valid", n), bus.resp_valid, 1'b1);
         finish_txn();
      end

      // Async reset while in SEND clears outputs immediately.
      bus.req_valid = 1'b1;
      tx_frm_offset = frame_length;
      step();
      check("rst_send_po_valid", bus.payload_o_valid, 1'b1);
      check("rst_send_tag", bus.payload_o.tag, exp_tag);
      bus.req_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("rstn");
      step();
      reset_n = 1'b1;
      tx_frm_offset = 4'd0;
      step();
      check("rstn_idle_po_valid", bus.payload_o_valid, 1'b0);
      check("rstn_idle_rvalid", bus.resp_valid, 1'b0);
      exp_tag = 8'h00;
      start_txn(32'd0);
      send_rsp(exp_tag);
      check("rstn_after_resp", bus.resp, with_tag(rsp_base, 8'h00));
      finish_txn();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
